// File: rtl/scanline_mixer.sv
// scanline_mixer: pixel post-processing between core video and OSD.
// Widens colour IN_W -> OUT_W by MSB replication, optional monochrome,
// scanline darkening with level/period/phase taken from shadow registers
// loaded at the vs_in falling edge. Three ce_pix-gated stages, syncs matched.
//
// Ports:
//   clk_sys, reset_n (async, active low), ce_pix (pipeline enable)
//   r_in/g_in/b_in [IN_W], hs_in, vs_in, de_in       : input pixel + syncs
//   mono, sl_level[3], sl_period[2], sl_phase[2]     : config (shadowed)
//   r_out/g_out/b_out [OUT_W], hs_out, vs_out, de_out: delayed output
//   line_dark                                        : output pixel is on a darkened line
module scanline_mixer #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 8
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             ce_pix,
  input  logic [IN_W-1:0]  r_in,
  input  logic [IN_W-1:0]  g_in,
  input  logic [IN_W-1:0]  b_in,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic             de_in,
  input  logic             mono,
  input  logic [2:0]       sl_level,
  input  logic [1:0]       sl_period,
  input  logic [1:0]       sl_phase,
  output logic [OUT_W-1:0] r_out,
  output logic [OUT_W-1:0] g_out,
  output logic [OUT_W-1:0] b_out,
  output logic             hs_out,
  output logic             vs_out,
  output logic             de_out,
  output logic             line_dark
);

  // Bit-wise replication: top IN_W bits are x, remaining low bits repeat
  // x from its MSB down. Works for OUT_W == IN_W without a zero-width slice.
  function automatic logic [OUT_W-1:0] expand(input logic [IN_W-1:0] x);
    logic [OUT_W-1:0] e;
    e = '0;
    for (int unsigned i = 0; i < OUT_W; i++)
      e[OUT_W-1-i] = x[IN_W-1-(i % IN_W)];
    return e;
  endfunction

  function automatic logic [OUT_W-1:0] attenuate(input logic [OUT_W-1:0] c,
                                                 input logic [2:0] lvl);
    logic [3:0]       factor;
    logic [OUT_W+3:0] prod;
    factor = 4'd8 - {1'b0, lvl};
    prod   = {4'b0, c} * {{OUT_W{1'b0}}, factor};
    return prod[OUT_W+2:3];
  endfunction

  // edge detect and shadow config
  logic       hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic       mono_sh_q, mono_sh_d;
  logic [2:0] sl_level_sh_q, sl_level_sh_d;
  logic [1:0] sl_period_sh_q, sl_period_sh_d;
  logic [1:0] sl_phase_sh_q, sl_phase_sh_d;
  logic [1:0] cnt_q, cnt_d;
  logic       hs_fall, vs_fall, dark;

  // pipeline stages
  logic [OUT_W-1:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
  logic             dark1_q, dark1_d, hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d;
  logic [OUT_W-1:0] r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
  logic             dark2_q, dark2_d, hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d;
  logic [OUT_W-1:0] r3_q, r3_d, g3_q, g3_d, b3_q, b3_d;
  logic             dark3_q, dark3_d, hs3_q, hs3_d, vs3_q, vs3_d, de3_q, de3_d;

  logic [OUT_W+2:0] luma_sum;

  assign hs_fall = hs_prev_q & ~hs_in;
  assign vs_fall = vs_prev_q & ~vs_in;
  assign dark    = (sl_period_sh_q != 2'd0) && (sl_level_sh_q != 3'd0) &&
                   (cnt_q == sl_phase_sh_q);

  always_comb begin
    hs_prev_d      = hs_in;
    vs_prev_d      = vs_in;
    mono_sh_d      = mono_sh_q;
    sl_level_sh_d  = sl_level_sh_q;
    sl_period_sh_d = sl_period_sh_q;
    sl_phase_sh_d  = sl_phase_sh_q;
    cnt_d          = cnt_q;

    if (vs_fall) begin
      mono_sh_d      = mono;
      sl_level_sh_d  = sl_level;
      sl_period_sh_d = sl_period;
      sl_phase_sh_d  = sl_phase;
    end

    if (vs_fall)
      cnt_d = 2'd0;
    else if (hs_fall) begin
      if (sl_period_sh_q == 2'd0 || cnt_q == sl_period_sh_q)
        cnt_d = 2'd0;
      else
        cnt_d = cnt_q + 2'd1;
    end
  end

  always_comb begin
    r1_d = r1_q; g1_d = g1_q; b1_d = b1_q;
    dark1_d = dark1_q; hs1_d = hs1_q; vs1_d = vs1_q; de1_d = de1_q;
    r2_d = r2_q; g2_d = g2_q; b2_d = b2_q;
    dark2_d = dark2_q; hs2_d = hs2_q; vs2_d = vs2_q; de2_d = de2_q;
    r3_d = r3_q; g3_d = g3_q; b3_d = b3_q;
    dark3_d = dark3_q; hs3_d = hs3_q; vs3_d = vs3_q; de3_d = de3_q;

    luma_sum = {2'b0, r1_q, 1'b0} + {1'b0, g1_q, 2'b0} + {3'b0, g1_q} + {3'b0, b1_q};

    if (ce_pix) begin
      // stage 1: widen
      r1_d    = expand(r_in);
      g1_d    = expand(g_in);
      b1_d    = expand(b_in);
      dark1_d = dark;
      hs1_d   = hs_in;
      vs1_d   = vs_in;
      de1_d   = de_in;

      // stage 2: monochrome
      if (mono_sh_q) begin
        r2_d = luma_sum[OUT_W+2:3];
        g2_d = luma_sum[OUT_W+2:3];
        b2_d = luma_sum[OUT_W+2:3];
      end else begin
        r2_d = r1_q;
        g2_d = g1_q;
        b2_d = b1_q;
      end
      dark2_d = dark1_q;
      hs2_d   = hs1_q;
      vs2_d   = vs1_q;
      de2_d   = de1_q;

      // stage 3: darkening and blanking
      if (!de2_q) begin
        r3_d = '0;
        g3_d = '0;
        b3_d = '0;
      end else if (dark2_q) begin
        r3_d = attenuate(r2_q, sl_level_sh_q);
        g3_d = attenuate(g2_q, sl_level_sh_q);
        b3_d = attenuate(b2_q, sl_level_sh_q);
      end else begin
        r3_d = r2_q;
        g3_d = g2_q;
        b3_d = b2_q;
      end
      dark3_d = dark2_q;
      hs3_d   = hs2_q;
      vs3_d   = vs2_q;
      de3_d   = de2_q;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev_q <= 1'b0; vs_prev_q <= 1'b0;
      mono_sh_q <= 1'b0; sl_level_sh_q <= '0; sl_period_sh_q <= '0; sl_phase_sh_q <= '0;
      cnt_q <= '0;
      r1_q <= '0; g1_q <= '0; b1_q <= '0;
      dark1_q <= 1'b0; hs1_q <= 1'b0; vs1_q <= 1'b0; de1_q <= 1'b0;
      r2_q <= '0; g2_q <= '0; b2_q <= '0;
      dark2_q <= 1'b0; hs2_q <= 1'b0; vs2_q <= 1'b0; de2_q <= 1'b0;
      r3_q <= '0; g3_q <= '0; b3_q <= '0;
      dark3_q <= 1'b0; hs3_q <= 1'b0; vs3_q <= 1'b0; de3_q <= 1'b0;
    end else begin
      hs_prev_q <= hs_prev_d; vs_prev_q <= vs_prev_d;
      mono_sh_q <= mono_sh_d; sl_level_sh_q <= sl_level_sh_d;
      sl_period_sh_q <= sl_period_sh_d; sl_phase_sh_q <= sl_phase_sh_d;
      cnt_q <= cnt_d;
      r1_q <= r1_d; g1_q <= g1_d; b1_q <= b1_d;
      dark1_q <= dark1_d; hs1_q <= hs1_d; vs1_q <= vs1_d; de1_q <= de1_d;
      r2_q <= r2_d; g2_q <= g2_d; b2_q <= b2_d;
      dark2_q <= dark2_d; hs2_q <= hs2_d; vs2_q <= vs2_d; de2_q <= de2_d;
      r3_q <= r3_d; g3_q <= g3_d; b3_q <= b3_d;
      dark3_q <= dark3_d; hs3_q <= hs3_d; vs3_q <= vs3_d; de3_q <= de3_d;
    end
  end

  assign r_out     = r3_q;
  assign g_out     = g3_q;
  assign b_out     = b3_q;
  assign hs_out    = hs3_q;
  assign vs_out    = vs3_q;
  assign de_out    = de3_q;
  assign line_dark = dark3_q;

endmodule

// File: tb/tb_scanline_mixer.sv
module tb_scanline_mixer;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       ce_pix;
  logic [5:0] r_in, g_in, b_in;
  logic       hs_in, vs_in, de_in;
  logic       mono;
  logic [2:0] sl_level;
  logic [1:0] sl_period, sl_phase;
  logic [7:0] r_out, g_out, b_out;
  logic       hs_out, vs_out, de_out, line_dark;

  int vectors = 0;
  int miscompares = 0;

  scanline_mixer #(.IN_W(6), .OUT_W(8)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .mono(mono), .sl_level(sl_level), .sl_period(sl_period), .sl_phase(sl_phase),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out), .line_dark(line_dark)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic pix(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
    r_in = r; g_in = g; b_in = b;
  endtask

  task automatic line_pulse();
    hs_in = 1'b1; tick(1);
    hs_in = 1'b0; tick(1);
  endtask

  task automatic vs_pulse();
    vs_in = 1'b1; tick(1);
    vs_in = 1'b0; tick(1);
  endtask

  task automatic ce_pulse();
    ce_pix = 1'b1; tick(1);
    ce_pix = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ce_pix = 1'b1;
    pix(6'h00, 6'h00, 6'h00);
    hs_in = 1'b0; vs_in = 1'b0; de_in = 1'b1;
    mono = 1'b0; sl_level = 3'd0; sl_period = 2'd0; sl_phase = 2'd0;
    tick(3);
    chk("rst_r", r_out, 8'h00);
    chk("rst_de", de_out, 1'b0);
    chk("rst_dark", line_dark, 1'b0);
    reset_n = 1'b1;
    tick(1);

    // widening, no darkening
    pix(6'h3F, 6'h20, 6'h00);
    tick(3);
    chk("wide_r", r_out, 8'hFF);
    chk("wide_g", g_out, 8'h82);
    chk("wide_b", b_out, 8'h00);
    chk("wide_dark", line_dark, 1'b0);
    chk("wide_de", de_out, 1'b1);

    // level 4, every 2nd line, phase 0
    sl_level = 3'd4; sl_period = 2'd1; sl_phase = 2'd0;
    vs_pulse();
    pix(6'h3F, 6'h3F, 6'h3F);
    tick(3);
    chk("p2_l0_r", r_out, 8'h7F);
    chk("p2_l0_dark", line_dark, 1'b1);
    line_pulse(); tick(3);
    chk("p2_l1_r", r_out, 8'hFF);
    chk("p2_l1_dark", line_dark, 1'b0);
    line_pulse(); tick(3);
    chk("p2_l2_r", r_out, 8'h7F);
    chk("p2_l2_dark", line_dark, 1'b1);

    // mid-frame config change has no effect until vs
    sl_level = 3'd2;
    tick(3);
    chk("mid_hold0", r_out, 8'h7F);
    line_pulse(); line_pulse(); tick(3);
    chk("mid_hold1", r_out, 8'h7F);
    vs_pulse();
    pix(6'h20, 6'h3F, 6'h00);
    tick(3);
    chk("lvl2_r", r_out, 8'h61);
    chk("lvl2_g", g_out, 8'hBF);
    chk("lvl2_b", b_out, 8'h00);

    // period 3, phase 1: dark lines 1, 4, 7
    sl_level = 3'd4; sl_period = 2'd2; sl_phase = 2'd1;
    vs_pulse();
    pix(6'h3F, 6'h3F, 6'h3F);
    for (int i = 0; i < 9; i++) begin
      tick(3);
      chk($sformatf("p3_line%0d_dark", i), line_dark, ((i % 3) == 1) ? 1'b1 : 1'b0);
      line_pulse();
    end

    // phase beyond period: never dark
    sl_phase = 2'd3;
    vs_pulse();
    for (int i = 0; i < 4; i++) begin
      tick(3);
      chk($sformatf("ph3_line%0d_dark", i), line_dark, 1'b0);
      line_pulse();
    end

    // hs and vs fall together: counter goes to 0 (phase 0 dark)
    sl_phase = 2'd0;
    vs_pulse();
    line_pulse(); tick(3);
    chk("both_pre_dark", line_dark, 1'b0);
    hs_in = 1'b1; vs_in = 1'b1; tick(1);
    hs_in = 1'b0; vs_in = 1'b0; tick(1);
    tick(3);
    chk("both_dark", line_dark, 1'b1);
    chk("both_r", r_out, 8'h7F);

    // monochrome
    mono = 1'b1; sl_level = 3'd0; sl_period = 2'd0; sl_phase = 2'd0;
    vs_pulse();
    pix(6'h3F, 6'h3F, 6'h3F);
    tick(3);
    chk("mono_w_r", r_out, 8'hFF);
    chk("mono_w_g", g_out, 8'hFF);
    chk("mono_w_b", b_out, 8'hFF);
    pix(6'h3F, 6'h00, 6'h00);
    tick(3);
    chk("mono_r_r", r_out, 8'h3F);
    chk("mono_r_g", g_out, 8'h3F);
    chk("mono_r_b", b_out, 8'h3F);

    // blanking with sync delay matching
    de_in = 1'b0; hs_in = 1'b1;
    tick(2);
    chk("blank_hs_early", hs_out, 1'b0);
    tick(1);
    chk("blank_hs", hs_out, 1'b1);
    chk("blank_de", de_out, 1'b0);
    chk("blank_r", r_out, 8'h00);
    chk("blank_g", g_out, 8'h00);
    hs_in = 1'b0; de_in = 1'b1;
    vs_in = 1'b1; tick(3);
    chk("vs_delay", vs_out, 1'b1);
    mono = 1'b0;
    vs_in = 1'b0; tick(1);

    // ce_pix at 1-in-4: flush with zeros first
    pix(6'h00, 6'h00, 6'h00);
    tick(3);
    ce_pix = 1'b0;
    pix(6'h10, 6'h01, 6'h3F);
    ce_pulse(); tick(3);
    pix(6'h00, 6'h00, 6'h00);
    ce_pulse();
    chk("ce_p2_r", r_out, 8'h00);
    tick(3);
    ce_pulse();
    chk("ce_p3_r", r_out, 8'h41);
    chk("ce_p3_g", g_out, 8'h04);
    chk("ce_p3_b", b_out, 8'hFF);
    tick(3);
    chk("ce_hold_r", r_out, 8'h41);
    chk("ce_hold_b", b_out, 8'hFF);
    ce_pix = 1'b1;

    // async reset mid-line clears shadow config
    sl_level = 3'd4; sl_period = 2'd1; sl_phase = 2'd0;
    vs_pulse();
    pix(6'h3F, 6'h3F, 6'h3F);
    tick(3);
    chk("prerst_r", r_out, 8'h7F);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_r", r_out, 8'h00);
    chk("async_rst_dark", line_dark, 1'b0);
    chk("async_rst_de", de_out, 1'b0);
    #2 reset_n = 1'b1;
    tick(3);
    chk("postrst_r", r_out, 8'hFF);
    chk("postrst_dark", line_dark, 1'b0);
    vs_pulse();
    tick(3);
    chk("postvs_r", r_out, 8'h7F);
    chk("postvs_dark", line_dark, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
